// File: rtl/lvds_rx_clk_align.sv
// lvds_rx_clk_align: 7:1 LVDS receive word aligner.
// Rotates clock and data lanes until the clock lane reads CLK_PATTERN.
module lvds_rx_clk_align #(
  parameter int         NUM_LANES     = 4,
  parameter logic [6:0] CLK_PATTERN   = 7'b1100011,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOCK_COUNT    = 16,
  parameter int         ERR_LIMIT     = 4
) (
  input  logic                   I_clk_1x,
  input  logic                   I_rst_n,
  input  logic [6:0]             I_clk_word,
  input  logic [7*NUM_LANES-1:0] I_data,
  output logic [7*NUM_LANES-1:0] O_data,
  output logic                   O_lock,
  output logic [2:0]             O_offset,
  output logic                   O_relock,
  output logic [15:0]            O_err_cnt
);

  localparam int DW = 7 * NUM_LANES;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    SEARCH,
    SETTLE,
    VERIFY,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [6:0]    clk_cur_q, clk_prev_q;
  logic [DW-1:0] dat_cur_q, dat_prev_q;
  logic [1:0]    vld_q;
  logic [2:0]    off_q, off_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [EW-1:0] mis_q, mis_d;
  logic          lock_q, lock_d;
  logic          relock_q, relock_d;
  logic [15:0]   err_q, err_d;
  logic [DW-1:0] data_q;

  logic [6:0]    clk_al;
  logic [DW-1:0] dat_al;
  logic          match;
  logic          hist_ok;
  logic [2:0]    off_adv;

  function automatic logic [6:0] rot_sel(
    input logic [13:0] cat,
    input logic [2:0]  off
  );
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[i] = cat[int'(off) + i];
    end
    return r;
  endfunction

  // Input history: two words per lane, plus a fill flag so the first
  // comparisons only happen once both history words hold real input.
  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) begin
      clk_cur_q  <= '0;
      clk_prev_q <= '0;
      dat_cur_q  <= '0;
      dat_prev_q <= '0;
      vld_q      <= '0;
    end else begin
      clk_cur_q  <= I_clk_word;
      clk_prev_q <= clk_cur_q;
      dat_cur_q  <= I_data;
      dat_prev_q <= dat_cur_q;
      vld_q      <= {vld_q[0], 1'b1};
    end
  end

  // Barrel select of the clock lane and all data lanes at the current offset.
  always_comb begin
    clk_al = rot_sel({clk_prev_q, clk_cur_q}, off_q);
    dat_al = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      dat_al[7*n +: 7] = rot_sel({dat_prev_q[7*n +: 7],
                                  dat_cur_q[7*n +: 7]}, off_q);
    end
  end

  assign match   = (clk_al == CLK_PATTERN);
  assign hist_ok = vld_q[1];
  assign off_adv = (off_q == 3'd6) ? 3'd0 : off_q + 3'd1;

  // Alignment FSM: search, settle after each offset change, verify, track.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    settle_d = settle_q;
    match_d  = match_q;
    mis_d    = mis_q;
    lock_d   = lock_q;
    relock_d = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      SEARCH: begin
        if (hist_ok) begin
          if (match) begin
            state_d = VERIFY;
            match_d = MW'(1);
          end else begin
            off_d    = off_adv;
            settle_d = '0;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SEARCH;
        end
      end
      VERIFY: begin
        if (match) begin
          match_d = match_q + MW'(1);
          if (match_q + MW'(1) == MW'(LOCK_COUNT)) begin
            state_d = LOCKED;
            lock_d  = 1'b1;
            mis_d   = '0;
          end
        end else begin
          match_d  = '0;
          off_d    = off_adv;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      LOCKED: begin
        if (match) begin
          mis_d = '0;
        end else begin
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
          if (mis_q == EW'(ERR_LIMIT - 1)) begin
            mis_d    = '0;
            match_d  = '0;
            lock_d   = 1'b0;
            relock_d = 1'b1;
            off_d    = off_adv;
            settle_d = '0;
            state_d  = SETTLE;
          end else begin
            mis_d = mis_q + EW'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge I_clk_1x or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= SEARCH;
      off_q    <= '0;
      settle_q <= '0;
      match_q  <= '0;
      mis_q    <= '0;
      lock_q   <= 1'b0;
      relock_q <= 1'b0;
      err_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      mis_q    <= mis_d;
      lock_q   <= lock_d;
      relock_q <= relock_d;
      err_q    <= err_d;
      data_q   <= dat_al;
    end
  end

  assign O_data    = data_q;
  assign O_lock    = lock_q;
  assign O_offset  = off_q;
  assign O_relock  = relock_q;
  assign O_err_cnt = err_q;

endmodule

// File: tb/tb_lvds_rx_clk_align.sv
// tb_lvds_rx_clk_align: directed checks of the LVDS word aligner.
// Covers reset, search, glitches, loss of lock, no-lock sweep, reset in lock.
module tb_lvds_rx_clk_align;

  localparam logic [6:0] P  = 7'b1100011;
  localparam int         NL = 4;

  logic            clk;
  logic            rst_n;
  logic [6:0]      clk_word;
  logic [7*NL-1:0] din;
  logic [7*NL-1:0] dout;
  logic            lock;
  logic [2:0]      offset;
  logic            relock;
  logic [15:0]     err_cnt;

  int n_chk;
  int n_err;

  logic [7*NL-1:0] D_ALL;
  assign D_ALL = {7'h61, 7'h33, 7'h0F, 7'h55};

  lvds_rx_clk_align dut (
    .I_clk_1x   (clk),
    .I_rst_n    (rst_n),
    .I_clk_word (clk_word),
    .I_data     (din),
    .O_data     (dout),
    .O_lock     (lock),
    .O_offset   (offset),
    .O_relock   (relock),
    .O_err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] rotl(input logic [6:0] w, input int s);
    logic [6:0] r;
    r = w;
    for (int i = 0; i < s; i++) r = {r[5:0], r[6]};
    return r;
  endfunction

  task automatic set_stream(input int s);
    logic [7*NL-1:0] d;
    d = D_ALL;
    clk_word = rotl(P, s);
    for (int n = 0; n < NL; n++) din[7*n +: 7] = rotl(d[7*n +: 7], s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_lock(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!lock && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, lock}, 64'd1);
  endtask

  initial begin
    int nz;
    int rl;
    int drop;
    int chg;
    int step_bad;
    int gap_bad;
    int last_chg;
    int lock_seen;
    logic [2:0] prev_off;
    logic [6:0] bad3;
    logic [6:0] bad0;

    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    clk_word = '0;
    din      = '0;
    #23;
    chk("rst_data", {36'd0, dout}, 64'd0);
    chk("rst_lock", {63'd0, lock}, 64'd0);
    chk("rst_off", {61'd0, offset}, 64'd0);
    chk("rst_relock", {63'd0, relock}, 64'd0);
    chk("rst_err", {48'd0, err_cnt}, 64'd0);

    // T1: aligned stream; 2 fill + 1 search + 15 verify edges = 18
    set_stream(0);
    release_rst();
    nz = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (offset != 3'd0) nz++;
    end
    chk("t1_nolock17", {63'd0, lock}, 64'd0);
    chk("t1_off_stay0", 64'(nz), 64'd0);
    tick();
    chk("t1_lock18", {63'd0, lock}, 64'd1);
    chk("t1_off", {61'd0, offset}, 64'd0);
    chk("t1_lane0", {57'd0, dout[6:0]}, 64'h55);
    chk("t1_data", {36'd0, dout}, {36'd0, D_ALL});

    // T2: rotation 3; offsets 0..2 cost 3 cycles each -> lock at edge 27
    do_reset();
    set_stream(3);
    release_rst();
    for (int i = 1; i <= 26; i++) tick();
    chk("t2_nolock26", {63'd0, lock}, 64'd0);
    tick();
    chk("t2_lock27", {63'd0, lock}, 64'd1);
    chk("t2_off", {61'd0, offset}, 64'd3);
    chk("t2_data", {36'd0, dout}, {36'd0, D_ALL});

    // T3: 3 corrupted words (bit 6 only touches cur at offset 3), twice
    bad3 = rotl(P, 3) ^ 7'h40;
    rl   = 0;
    drop = 0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        clk_word = bad3;
        tick();
        if (relock) rl++;
        if (!lock) drop++;
      end
      set_stream(3);
      for (int i = 0; i < 4; i++) begin
        tick();
        if (relock) rl++;
        if (!lock) drop++;
      end
      if (b == 0) chk("t3_err3", {48'd0, err_cnt}, 64'd3);
    end
    chk("t3_err6", {48'd0, err_cnt}, 64'd6);
    chk("t3_no_relock", 64'(rl), 64'd0);
    chk("t3_no_drop", 64'(drop), 64'd0);
    chk("t3_lock", {63'd0, lock}, 64'd1);

    // T4: lock at 6, then shift by 2 -> drop, wrap to 0, relock at 1
    do_reset();
    set_stream(6);
    release_rst();
    wait_lock("t4_lock6", 100);
    chk("t4_off6", {61'd0, offset}, 64'd6);
    set_stream(8);
    rl = 0;
    for (int i = 0; i < 20 && rl == 0; i++) begin
      tick();
      if (relock) begin
        rl++;
        chk("t4_lock_low", {63'd0, lock}, 64'd0);
        chk("t4_wrap0", {61'd0, offset}, 64'd0);
      end
    end
    chk("t4_pulse_seen", 64'(rl), 64'd1);
    for (int i = 0; i < 60 && !lock; i++) begin
      tick();
      if (relock) rl++;
    end
    chk("t4_relock", {63'd0, lock}, 64'd1);
    chk("t4_pulse_once", 64'(rl), 64'd1);
    chk("t4_off1", {61'd0, offset}, 64'd1);
    chk("t4_data", {36'd0, dout}, {36'd0, D_ALL});
    chk("t4_err4", {48'd0, err_cnt}, 64'd4);

    // T5: dead clock lane; offset steps every 3 cycles, wrapping 6->0
    do_reset();
    clk_word = 7'h00;
    din      = '0;
    release_rst();
    chg       = 0;
    step_bad  = 0;
    gap_bad   = 0;
    last_chg  = 0;
    lock_seen = 0;
    prev_off  = 3'd0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (lock) lock_seen++;
      if (offset != prev_off) begin
        if (offset != ((prev_off == 3'd6) ? 3'd0 : prev_off + 3'd1))
          step_bad++;
        if (chg > 0 && i - last_chg != 3) gap_bad++;
        if (chg == 0 && i != 3) gap_bad++;
        chg++;
        last_chg = i;
        prev_off = offset;
      end
    end
    chk("t5_no_lock", 64'(lock_seen), 64'd0);
    chk("t5_changes", 64'(chg), 64'd21);
    chk("t5_step", 64'(step_bad), 64'd0);
    chk("t5_period", 64'(gap_bad), 64'd0);
    chk("t5_off_end", {61'd0, offset}, 64'd0);

    // T6: reset while LOCKED with err_cnt=5, then reacquire
    do_reset();
    set_stream(0);
    release_rst();
    wait_lock("t6_lock", 40);
    bad0 = P ^ 7'h01;
    clk_word = bad0; tick();
    clk_word = bad0; tick();
    clk_word = bad0; tick();
    clk_word = P;    tick();
    clk_word = bad0; tick();
    clk_word = bad0; tick();
    clk_word = P;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_err5", {48'd0, err_cnt}, 64'd5);
    chk("t6_lock_held", {63'd0, lock}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_lock", {63'd0, lock}, 64'd0);
    chk("t6_async_err", {48'd0, err_cnt}, 64'd0);
    chk("t6_async_data", {36'd0, dout}, 64'd0);
    chk("t6_async_off", {61'd0, offset}, 64'd0);
    chk("t6_async_rl", {63'd0, relock}, 64'd0);
    release_rst();
    for (int i = 1; i <= 17; i++) tick();
    chk("t6_nolock17", {63'd0, lock}, 64'd0);
    tick();
    chk("t6_lock18", {63'd0, lock}, 64'd1);
    chk("t6_off", {61'd0, offset}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lvds_rx_clk_align.md
Name: lvds_rx_clk_align

Overview:
- Receive-side word aligner for the 7:1 LVDS link, on the pixel clock after the input deserialisers.
- Searches the 7 bit-rotations of the deserialised LVDS clock lane until it equals the transmitted clock pattern.
- Applies the same rotation to all data lanes and reports lock.
- Tracks alignment loss and re-searches automatically.

Parameters:
- NUM_LANES, 4: number of 7-bit data lanes aligned with the clock lane.
- CLK_PATTERN, 7'b1100011: expected clock-lane word, bit 6 = first serial bit.
- SETTLE_CYCLES, 2: wait cycles after each offset change before comparing again.
- LOCK_COUNT, 16: consecutive matches required to declare lock.
- ERR_LIMIT, 4: consecutive mismatches in LOCKED that drop lock.

Ports:
- I_clk_1x  input  1  pixel clock; all logic on rising edge.
- I_rst_n  input  1  asynchronous active-low reset.
- I_clk_word  input  7  deserialised clock-lane word.
- I_data  input  7*NUM_LANES  deserialised data lanes; lane n at [7n+6:7n].
- O_data  output  7*NUM_LANES  aligned data lanes, registered.
- O_lock  output  1  alignment locked.
- O_offset  output  3  current rotation offset, 0..6.
- O_relock  output  1  one-cycle pulse when lock is lost.
- O_err_cnt  output  16  saturating count of single-word mismatches while locked.

Behaviour:
- Reset (async assert, sync release): all history registers 0; state SEARCH; O_data=0; O_lock=0; O_offset=0; O_relock=0; O_err_cnt=0; settle, match and mismatch counters 0.
- Input history:
  - Each cycle cur<=input and prev<=cur, for the clock lane and every data lane.
  - cat={prev,cur}, 14 bits.
  - aligned=cat[offset+6:offset]; offset 0 selects cur.
- Compare:
  - match = (aligned clock word == CLK_PATTERN).
  - Combinational from registered history and the offset register.
- Data path:
  - O_data <= aligned data every cycle, in all states.
  - Latency is 2 cycles from I_data to O_data.
  - The new offset applies to O_data one cycle after O_offset changes.
- Offset advance: offset <= (offset==6)?0:offset+1.
- SEARCH:
  - match -> VERIFY, match_cnt=1.
  - Else advance offset -> SETTLE, settle_cnt=0.
- SETTLE:
  - Increment settle_cnt.
  - When settle_cnt==SETTLE_CYCLES-1 -> SEARCH.
  - No comparisons are made in this state.
- VERIFY:
  - match: match_cnt++. On reaching LOCK_COUNT -> LOCKED, O_lock<=1.
  - Mismatch: match_cnt=0, advance offset -> SETTLE.
- LOCKED:
  - Mismatch: O_err_cnt++ (saturates at 16'hFFFF) and mis_cnt++.
  - match: mis_cnt=0.
  - When mis_cnt reaches ERR_LIMIT: O_lock<=0, O_relock=1 for one cycle, advance offset, -> SETTLE. O_err_cnt is kept.
- Wrap-around: offset 6 advances to 0. Search repeats indefinitely with no timeout.
- O_err_cnt clears only on reset.
- Reset mid-operation: immediate return to reset values, including mid-SETTLE and in LOCKED.
- A match in the same cycle that mis_cnt would reach ERR_LIMIT is not possible; a match resets mis_cnt first.
- O_offset is valid in all states. O_data is meaningful only while O_lock=1.

Test Plan:
1. Clock lane driven continuously with CLK_PATTERN (stream rotation 0), data lane0=7'h55 -> VERIFY entered at offset 0; O_lock=1 exactly LOCK_COUNT+2 cycles after the first valid word; O_offset=0; O_data[6:0]=7'h55.
2. Clock stream delayed by 3 serial bits -> offsets 0,1,2 rejected, each costing 1+SETTLE_CYCLES cycles; lock at O_offset=3; data lanes delayed identically reproduce the transmitted words on O_data.
3. Locked, then 3 corrupted clock words followed by a good one -> O_lock stays 1; O_err_cnt=3; mis_cnt back to 0; no O_relock.
4. Locked, then stream shifted by 2 bits permanently -> O_relock pulses once after ERR_LIMIT mismatches; O_lock=0; re-lock reached at offset (old+2) mod 7 after wrap.
5. Clock lane held at 7'h00 -> O_lock never asserts; O_offset cycles 0..6, 0.. with period 7*(1+SETTLE_CYCLES).
6. I_rst_n pulsed low while LOCKED with O_err_cnt=5 -> all outputs return to reset values asynchronously; lock reacquired as in test 1.
